// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of inserted hazard bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_RegWrite,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic              id_RegDst,
    input  logic              id_MemtoReg,
    input  logic              id_signed_D,
    input  logic              id_jump,
    input  logic              id_jumpR,
    input  logic              id_update_signal,
    input  logic [2:0]        id_ALUcontrol,
    input  logic [2:0]        id_Branch,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    output logic              stall,
    output logic              ex_RegWrite,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc,
    output logic              ex_RegDst,
    output logic              ex_MemtoReg,
    output logic              ex_signed_D,
    output logic              ex_jump,
    output logic              ex_jumpR,
    output logic              ex_update_signal,
    output logic [2:0]        ex_ALUcontrol,
    output logic [2:0]        ex_Branch,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_dest,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              RegWrite;
        logic              MemWrite;
        logic              ALUSrc;
        logic              RegDst;
        logic              MemtoReg;
        logic              signed_D;
        logic              jump;
        logic              jumpR;
        logic              update_signal;
        logic [2:0]        ALUcontrol;
        logic [2:0]        Branch;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  dest;
    } ex_t;

    ex_t              ex_q, ex_d, cap;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uses_rs, uses_rt, hazard;

    // A bubble has MemtoReg=0, so a hazard can never persist past one cycle.
    always_comb begin
        uses_rs = !id_jump;
        uses_rt = id_RegDst | id_MemWrite | (id_Branch != 3'd0);
        hazard  = ex_q.MemtoReg & ex_q.RegWrite & (ex_q.dest != '0) &
                  ((uses_rs & (ex_q.dest == id_rs)) | (uses_rt & (ex_q.dest == id_rt)));
    end

    assign stall = hazard & !hold & !flush;

    always_comb begin
        cap.RegWrite      = id_RegWrite;
        cap.MemWrite      = id_MemWrite;
        cap.ALUSrc        = id_ALUSrc;
        cap.RegDst        = id_RegDst;
        cap.MemtoReg      = id_MemtoReg;
        cap.signed_D      = id_signed_D;
        cap.jump          = id_jump;
        cap.jumpR         = id_jumpR;
        cap.update_signal = id_update_signal;
        cap.ALUcontrol    = id_ALUcontrol;
        cap.Branch        = id_Branch;
        cap.pc4           = id_pc4;
        cap.rs_data       = id_rs_data;
        cap.rt_data       = id_rt_data;
        // signed_D=1 marks the logical-immediate ops, which zero-extend
        cap.imm           = id_signed_D ? {{(DATA_W-16){1'b0}}, id_imm}
                                        : {{(DATA_W-16){id_imm[15]}}, id_imm};
        cap.rs            = id_rs;
        cap.rt            = id_rt;
        cap.dest          = id_jump ? REG_W'(31) : (id_RegDst ? id_rd : id_rt);
    end

    always_comb begin
        ex_d  = cap;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (hazard) begin
            ex_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else if (!hold) begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_RegWrite      = ex_q.RegWrite;
    assign ex_MemWrite      = ex_q.MemWrite;
    assign ex_ALUSrc        = ex_q.ALUSrc;
    assign ex_RegDst        = ex_q.RegDst;
    assign ex_MemtoReg      = ex_q.MemtoReg;
    assign ex_signed_D      = ex_q.signed_D;
    assign ex_jump          = ex_q.jump;
    assign ex_jumpR         = ex_q.jumpR;
    assign ex_update_signal = ex_q.update_signal;
    assign ex_ALUcontrol    = ex_q.ALUcontrol;
    assign ex_Branch        = ex_q.Branch;
    assign ex_pc4           = ex_q.pc4;
    assign ex_rs_data       = ex_q.rs_data;
    assign ex_rt_data       = ex_q.rt_data;
    assign ex_rs            = ex_q.rs;
    assign ex_rt            = ex_q.rt;
    assign ex_imm           = ex_q.imm;
    assign ex_dest          = ex_q.dest;
    assign bubble_cnt       = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed + random stimulus, reference model feeding
// a scoreboard queue that a free-running monitor drains each cycle.
module tb_id_ex_stage;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    // ctrl packing: {RW, MW, ALUSrc, RegDst, MtoR, signed_D, jump, jumpR, upd, ALUc[2:0], Br[2:0]}
    localparam logic [14:0] LW   = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,3'd0};
    localparam logic [14:0] ADD  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'd2,3'd0};
    localparam logic [14:0] ADDI = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd2,3'd0};
    localparam logic [14:0] ORI  = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,3'd1,3'd0};
    localparam logic [14:0] SW   = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd2,3'd0};
    localparam logic [14:0] JAL  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,3'd0,3'd0};

    typedef struct {
        logic [14:0] ctrl;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  rs, rt, dest;
        int          cnt;
        logic        stall;
    } exp_t;

    logic clk, rst, hold, flush;
    logic [14:0] i_ctrl;
    logic [31:0] i_pc4, i_rsd, i_rtd;
    logic [15:0] i_imm;
    logic [4:0]  i_rs, i_rt, i_rd;

    logic        stall;
    logic        ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_RegDst, ex_MemtoReg;
    logic        ex_signed_D, ex_jump, ex_jumpR, ex_update_signal;
    logic [2:0]  ex_ALUcontrol, ex_Branch;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [CNT_W-1:0] bubble_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t m;
    exp_t sb[$];

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_RegWrite(i_ctrl[14]), .id_MemWrite(i_ctrl[13]), .id_ALUSrc(i_ctrl[12]),
        .id_RegDst(i_ctrl[11]), .id_MemtoReg(i_ctrl[10]), .id_signed_D(i_ctrl[9]),
        .id_jump(i_ctrl[8]), .id_jumpR(i_ctrl[7]), .id_update_signal(i_ctrl[6]),
        .id_ALUcontrol(i_ctrl[5:3]), .id_Branch(i_ctrl[2:0]),
        .id_pc4(i_pc4), .id_rs_data(i_rsd), .id_rt_data(i_rtd), .id_imm(i_imm),
        .id_rs(i_rs), .id_rt(i_rt), .id_rd(i_rd),
        .stall(stall),
        .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_RegDst(ex_RegDst), .ex_MemtoReg(ex_MemtoReg), .ex_signed_D(ex_signed_D),
        .ex_jump(ex_jump), .ex_jumpR(ex_jumpR), .ex_update_signal(ex_update_signal),
        .ex_ALUcontrol(ex_ALUcontrol), .ex_Branch(ex_Branch),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_dest(ex_dest),
        .bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [14:0] act_ctrl();
        return {ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_RegDst, ex_MemtoReg, ex_signed_D,
                ex_jump, ex_jumpR, ex_update_signal, ex_ALUcontrol, ex_Branch};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'(act_ctrl()), 32'd0);
        check({tag, "_pc4"}, ex_pc4, 32'd0);
        check({tag, "_rsd"}, ex_rs_data, 32'd0);
        check({tag, "_rtd"}, ex_rt_data, 32'd0);
        check({tag, "_imm"}, ex_imm, 32'd0);
        check({tag, "_regs"}, {17'd0, ex_rs, ex_rt, ex_dest}, 32'd0);
        check({tag, "_cnt"}, 32'(bubble_cnt), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    task automatic set_in(input logic [14:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm,
                          input logic h, input logic f);
        i_ctrl = c; i_rs = rs; i_rt = rt; i_rd = rd; i_imm = imm;
        hold = h; flush = f;
        i_pc4 = $urandom; i_rsd = $urandom; i_rtd = $urandom;
    endtask

    // Reference model: one ID/EX clock edge described directly from the hazard rules.
    task automatic step();
        exp_t n;
        bit urs, urt, haz;
        #1;
        urs = !i_ctrl[8];
        urt = i_ctrl[11] || i_ctrl[13] || (i_ctrl[2:0] != 3'd0);
        haz = m.ctrl[10] && m.ctrl[14] && (m.dest != 5'd0) &&
              ((urs && m.dest == i_rs) || (urt && m.dest == i_rt));
        n = m;
        if (hold) begin
            n = m;
        end else if (flush || haz) begin
            n = '{default: '0};
            n.cnt = (!flush && haz) ? ((m.cnt < CNT_MAX) ? m.cnt + 1 : CNT_MAX) : m.cnt;
        end else begin
            n.ctrl = i_ctrl;
            n.pc4  = i_pc4;
            n.rsd  = i_rsd;
            n.rtd  = i_rtd;
            n.imm  = i_ctrl[9] ? {16'h0000, i_imm} : 32'($signed(i_imm));
            n.rs   = i_rs;
            n.rt   = i_rt;
            n.dest = i_ctrl[8] ? 5'd31 : (i_ctrl[11] ? i_rd : i_rt);
        end
        n.stall = haz && !hold && !flush;
        sb.push_back(n);
        m = n;
        m.stall = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: samples stall mid-low-phase, then ex_ state just after the edge.
    initial begin
        logic s;
        exp_t e;
        forever begin
            @(negedge clk);
            #2 s = stall;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("stall", 32'(s), 32'(e.stall));
                check("ctrl", 32'(act_ctrl()), 32'(e.ctrl));
                check("pc4", ex_pc4, e.pc4);
                check("rs_data", ex_rs_data, e.rsd);
                check("rt_data", ex_rt_data, e.rtd);
                check("imm", ex_imm, e.imm);
                check("rs", 32'(ex_rs), 32'(e.rs));
                check("rt", 32'(ex_rt), 32'(e.rt));
                check("dest", 32'(ex_dest), 32'(e.dest));
                check("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        m = '{default: '0};
        rst = 1'b1;
        set_in(ADD, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0, 1'b0);
        #3 check_all_zero("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // first edge after release captures
        set_in(ADD, 5'd4, 5'd5, 5'd6, 16'h00FF, 1'b0, 1'b0); step();

        // load-use on rs
        set_in(LW,  5'd1, 5'd8, 5'd0,  16'h0004, 1'b0, 1'b0); step();
        set_in(ADD, 5'd8, 5'd2, 5'd10, 16'h0000, 1'b0, 1'b0); step();
        step();

        // rt dependence: addi does not read rt, sw does
        set_in(LW,   5'd1, 5'd9, 5'd0, 16'h0008, 1'b0, 1'b0); step();
        set_in(ADDI, 5'd3, 5'd9, 5'd0, 16'h0010, 1'b0, 1'b0); step();
        set_in(LW,   5'd1, 5'd9, 5'd0, 16'h0008, 1'b0, 1'b0); step();
        set_in(SW,   5'd2, 5'd9, 5'd0, 16'h000C, 1'b0, 1'b0); step();
        step();

        // load to $zero never stalls
        set_in(LW,  5'd1, 5'd0, 5'd0,  16'h0000, 1'b0, 1'b0); step();
        set_in(ADD, 5'd0, 5'd0, 5'd11, 16'h0000, 1'b0, 1'b0); step();

        // extension and destination
        set_in(ADDI, 5'd1, 5'd12, 5'd0, 16'h8001, 1'b0, 1'b0); step();
        set_in(ORI,  5'd1, 5'd12, 5'd0, 16'h8001, 1'b0, 1'b0); step();
        set_in(JAL,  5'd7, 5'd7,  5'd7, 16'hFFFF, 1'b0, 1'b0); step();

        // flush beats hazard, then hold beats hazard
        set_in(LW,  5'd1, 5'd8, 5'd0,  16'h0000, 1'b0, 1'b0); step();
        set_in(ADD, 5'd8, 5'd2, 5'd10, 16'h0000, 1'b0, 1'b1); step();
        set_in(LW,  5'd1, 5'd8, 5'd0,  16'h0000, 1'b0, 1'b0); step();
        set_in(ADD, 5'd8, 5'd2, 5'd13, 16'h0000, 1'b1, 1'b0); step();
        set_in(ADD, 5'd8, 5'd2, 5'd13, 16'h0000, 1'b0, 1'b0); step();
        step();

        // saturation: five hazards in a row
        for (int k = 0; k < 5; k++) begin
            set_in(LW,  5'd1, 5'd8, 5'd0,  16'h0000, 1'b0, 1'b0); step();
            set_in(ADD, 5'd8, 5'd3, 5'd14, 16'h0000, 1'b0, 1'b0); step();
        end

        // asynchronous reset mid-hazard, then normal capture on release
        set_in(LW, 5'd1, 5'd8, 5'd0, 16'h0000, 1'b0, 1'b0); step();
        #3;
        set_in(ADD, 5'd8, 5'd2, 5'd15, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        #1 check_all_zero("reset_async");
        m = '{default: '0};
        @(negedge clk);
        rst = 1'b0;
        step();

        // randomized traffic over a small register set to provoke hazards
        for (int k = 0; k < 400; k++) begin
            logic [14:0] c;
            c = ($urandom_range(0, 2) == 0) ? LW : 15'($urandom);
            set_in(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 16'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            step();
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
